// File: rtl/maple_tx_pkg.sv
// Shared definitions for the Maple bus transmitter.
// Contents: FSM state encoding, default frame-shape parameters, the idle bus levels
// and a small helper used to size the phase counter.
package maple_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StSync,
    StSyncEnd,
    StData,
    StTail,
    StGuard
  } maple_state_e;

  localparam int unsigned DefSyncToggles = 8;
  localparam int unsigned DefTailPulses  = 2;
  localparam int unsigned DefGuardTicks  = 1;

  // Bus levels while no frame is being sent (matches the top-level tie-off).
  localparam logic IdleP1 = 1'b1;
  localparam logic IdleP5 = 1'b1;
  localparam logic IdleOe = 1'b0;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/maple_tx.sv
// Maple bus frame transmitter.
// Emits start pattern, MSB-first data and end pattern on SDCKA/SDCKB, one step per tick.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   tick                one-cycle step enable from the clock divider
//   start               pulse, begins a frame (ignored while busy)
//   data, data_valid,   byte stream; data_last marks the final byte
//   data_last
//   data_ready          pulse, byte consumed
//   busy, done          frame in progress / pulse on return to idle
//   underrun            pulse, a byte was needed but data_valid was low
//   out_p1, out_p5, oe  bus drive values and output enable
module maple_tx
  import maple_tx_pkg::*;
#(
  parameter int unsigned SYNC_TOGGLES = DefSyncToggles,
  parameter int unsigned TAIL_PULSES  = DefTailPulses,
  parameter int unsigned GUARD_TICKS  = DefGuardTicks
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic       out_p1,
  output logic       out_p5,
  output logic       oe
);

  localparam int unsigned PhaseMax = max3(SYNC_TOGGLES, 2 * TAIL_PULSES, GUARD_TICKS);
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);

  maple_state_e      state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              last_q, last_d;
  logic              p1_q, p1_d, p5_q, p5_d, oe_q, oe_d;
  logic              busy_q, busy_d, ready_q, ready_d, under_q, under_d, done_q, done_d;

  logic load, to_tail, drive_a, cur_bit;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    p1_d    = p1_q;
    p5_d    = p5_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    under_d = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    to_tail = 1'b0;
    drive_a = 1'b0;
    cur_bit = 1'b0;

    unique case (state_q)
      StIdle: begin
        // busy_q doubles as "start accepted, waiting for the next tick".
        if (!busy_q) begin
          if (start) busy_d = 1'b1;
        end else if (tick) begin
          state_d = StLead;
          oe_d    = 1'b1;
          p1_d    = 1'b1;
          p5_d    = 1'b1;
        end
      end
      StLead: begin
        if (tick) begin
          state_d = StSync;
          phase_d = PhaseW'(1);
          p1_d    = 1'b0;
          p5_d    = 1'b0;
        end
      end
      StSync: begin
        if (tick) begin
          if (phase_q == PhaseW'(SYNC_TOGGLES)) begin
            state_d = StSyncEnd;
            p1_d    = 1'b1;
            p5_d    = 1'b1;
          end else begin
            phase_d = phase_q + PhaseW'(1);
            p5_d    = ~p5_q;
          end
        end
      end
      StSyncEnd: begin
        if (tick) load = 1'b1;
      end
      StData: begin
        // phase_q[0] is the half-bit: 0 after tick a, 1 after tick b.
        if (tick) begin
          if (!phase_q[0]) begin
            phase_d = PhaseW'(1);
            if (bit_q[0]) p1_d = 1'b0;
            else          p5_d = 1'b0;
          end else if (bit_q == 3'd0) begin
            if (last_q) to_tail = 1'b1;
            else        load    = 1'b1;
          end else begin
            bit_d   = bit_q - 3'd1;
            phase_d = '0;
            drive_a = 1'b1;
          end
        end
      end
      StTail: begin
        if (tick) begin
          if (phase_q == PhaseW'(2 * TAIL_PULSES)) begin
            // Final p5-high tail step; GUARD keeps these levels.
            state_d = StGuard;
            phase_d = '0;
            p1_d    = 1'b1;
            p5_d    = 1'b1;
          end else begin
            phase_d = phase_q + PhaseW'(1);
            p1_d    = phase_q[0];
          end
        end
      end
      StGuard: begin
        if (tick) begin
          if (phase_q == PhaseW'(GUARD_TICKS)) begin
            state_d = StIdle;
            oe_d    = IdleOe;
            p1_d    = IdleP1;
            p5_d    = IdleP5;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (data_valid) begin
        ready_d = 1'b1;
        shift_d = data;
        last_d  = data_last;
        bit_d   = 3'd7;
        phase_d = '0;
        state_d = StData;
        drive_a = 1'b1;
      end else begin
        under_d = 1'b1;
        to_tail = 1'b1;
      end
    end

    // Tick a of a bit: odd bits clock on p1 with data on p5, even bits the reverse.
    if (drive_a) begin
      cur_bit = shift_d[bit_d];
      if (bit_d[0]) begin
        p1_d = 1'b1;
        p5_d = cur_bit;
      end else begin
        p5_d = 1'b1;
        p1_d = cur_bit;
      end
    end

    if (to_tail) begin
      state_d = StTail;
      phase_d = '0;
      p1_d    = 1'b1;
      p5_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      last_q  <= 1'b0;
      p1_q    <= IdleP1;
      p5_q    <= IdleP5;
      oe_q    <= IdleOe;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      under_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      p1_q    <= p1_d;
      p5_q    <= p5_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      under_q <= under_d;
      done_q  <= done_d;
    end
  end

  assign out_p1     = p1_q;
  assign out_p5     = p5_q;
  assign oe         = oe_q;
  assign busy       = busy_q;
  assign data_ready = ready_q;
  assign underrun   = under_q;
  assign done       = done_q;

endmodule

// File: tb/tb_maple_tx.sv
module tb_maple_tx;

  localparam int SyncToggles = 8;
  localparam int TailPulses  = 2;
  localparam int GuardTicks  = 1;
  localparam int FirstLoad   = SyncToggles + 3;  // tick index of the first byte load

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_last = 1'b0;
  logic       data_ready, busy, done, underrun, out_p1, out_p5, oe;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  maple_tx #(
    .SYNC_TOGGLES(SyncToggles),
    .TAIL_PULSES (TailPulses),
    .GUARD_TICKS (GuardTicks)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start     (start),
    .data      (data),
    .data_valid(data_valid),
    .data_last (data_last),
    .data_ready(data_ready),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .out_p1    (out_p1),
    .out_p5    (out_p5),
    .oe        (oe)
  );

  function automatic void check(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected {oe,p1,p5} after each tick of a frame, starting with LEAD.
  logic [7:0] fr_bytes[$];
  logic [2:0] exp_w[$];

  task automatic build_model(input int nsent);
    logic b;
    exp_w.delete();
    exp_w.push_back(3'b111);
    for (int i = 0; i < SyncToggles; i++) exp_w.push_back({2'b10, (i % 2) == 1});
    exp_w.push_back(3'b111);
    for (int k = 0; k < nsent; k++) begin
      for (int i = 7; i >= 0; i--) begin
        b = fr_bytes[k][i];
        if (i % 2 == 1) begin
          exp_w.push_back({2'b11, b});
          exp_w.push_back({2'b10, b});
        end else begin
          exp_w.push_back({1'b1, b, 1'b1});
          exp_w.push_back({1'b1, b, 1'b0});
        end
      end
    end
    exp_w.push_back(3'b110);
    for (int k = 0; k < TailPulses; k++) begin
      exp_w.push_back(3'b100);
      exp_w.push_back(3'b110);
    end
    exp_w.push_back(3'b111);
    for (int k = 0; k < GuardTicks; k++) exp_w.push_back(3'b111);
    exp_w.push_back(3'b011);
  endtask

  // Runs one frame from the start pulse to the done pulse (fr_bytes must be loaded).
  task automatic run_frame(input int nbytes, input int avail, input int gap, input bit coinc,
                           input bit bstart, output int ticks_o, output int ready_o,
                           output int under_o);
    int  bidx = 0;
    int  t = 0;
    int  bad_wave = 0;
    int  bad_pulse = 0;
    int  nsent;
    bit  fin = 1'b0;
    nsent = (avail < nbytes) ? avail : nbytes;
    under_o = 0;
    build_model(nsent);
    start = 1'b1;
    tick  = coinc;
    clk1();
    start = 1'b0;
    tick  = 1'b0;
    check("busy_after_start", busy, 1);
    if (coinc) check("coincident_tick_still_idle", {oe, out_p1, out_p5}, 3'b011);
    while (!fin && t < 400) begin
      data       = (bidx < nbytes) ? fr_bytes[bidx] : 8'h00;
      data_valid = (bidx < avail) && (bidx < nbytes);
      data_last  = (bidx == nbytes - 1);
      start      = bstart && (t == 5);
      tick       = 1'b1;
      clk1();
      tick  = 1'b0;
      start = 1'b0;
      t++;
      if (t <= int'(exp_w.size())) begin
        if ({oe, out_p1, out_p5} !== exp_w[t-1]) begin
          if (bad_wave == 0)
            $display("FAIL wave_tick%0d: got %b, expected %b", t, {oe, out_p1, out_p5},
                     exp_w[t-1]);
          bad_wave++;
        end
      end else begin
        bad_wave++;
      end
      if (data_ready) begin
        check("ready_tick", t, FirstLoad + 16 * bidx);
        bidx++;
      end
      if (underrun) begin
        under_o++;
        check("underrun_tick", t, FirstLoad + 16 * bidx);
      end
      if (done) begin
        fin = 1'b1;
        check("busy_low_at_done", busy, 0);
      end
      if (!fin) begin
        for (int g = 1; g < gap; g++) begin
          clk1();
          if (data_ready || underrun || done) bad_pulse++;
        end
      end
    end
    check("wave_mismatches", bad_wave, 0);
    check("pulse_width", bad_pulse, 0);
    check("frame_ticks", t, exp_w.size());
    check("ready_count", bidx, nsent);
    check("underrun_count", under_o, (avail < nbytes) ? 1 : 0);
    data_valid = 1'b0;
    ticks_o    = t;
    ready_o    = bidx;
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          nbytes;
    int          avail;
    int          gap;
    bit          coinc;
    bit          bstart;
    int          exp_ticks;
    int          exp_ready;
    int          exp_under;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bad;
    int tk, rd, un;
    int nb, av;

    vecs[0] = '{32'hA5000000, 1, 1, 4, 1'b0, 1'b0, 34, 1, 0};
    vecs[1] = '{32'h00FF3C00, 3, 3, 2, 1'b0, 1'b0, 66, 3, 0};
    vecs[2] = '{32'h12340000, 2, 1, 3, 1'b0, 1'b0, 34, 1, 1};
    vecs[3] = '{32'h77000000, 1, 0, 1, 1'b0, 1'b0, 18, 0, 1};
    vecs[4] = '{32'h81000000, 1, 1, 4, 1'b1, 1'b1, 34, 1, 0};
    vecs[5] = '{32'h96690000, 2, 2, 1, 1'b0, 1'b0, 50, 2, 0};

    // Reset state and idle hold.
    #12;
    check("reset_outputs", {oe, out_p1, out_p5, busy, data_ready, done, underrun}, 7'b0110000);
    rst_n = 1'b1;
    clk1();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick = 1'b1;
      clk1();
      tick = 1'b0;
      if ({oe, out_p1, out_p5, busy} !== 4'b0110) bad++;
      for (int g = 0; g < 3; g++) begin
        clk1();
        if ({oe, out_p1, out_p5, busy} !== 4'b0110) bad++;
      end
    end
    check("idle_hold", bad, 0);

    // Directed table; frames run back-to-back so each start lands in the done cycle.
    foreach (vecs[v]) begin
      fr_bytes.delete();
      for (int k = 0; k < vecs[v].nbytes; k++) fr_bytes.push_back(vecs[v].bytes[31-8*k -: 8]);
      run_frame(vecs[v].nbytes, vecs[v].avail, vecs[v].gap, vecs[v].coinc, vecs[v].bstart,
                tk, rd, un);
      check("table_ticks", tk, vecs[v].exp_ticks);
      check("table_ready", rd, vecs[v].exp_ready);
      check("table_underrun", un, vecs[v].exp_under);
    end

    // Asynchronous reset in the middle of DATA, then a clean frame.
    start = 1'b1;
    clk1();
    start      = 1'b0;
    data       = 8'h5A;
    data_valid = 1'b1;
    data_last  = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick = 1'b1;
      clk1();
      tick = 1'b0;
      clk1();
    end
    check("mid_frame_oe", oe, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {oe, out_p1, out_p5, busy}, 4'b0110);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    data_valid = 1'b0;
    clk1();
    fr_bytes.delete();
    fr_bytes.push_back(8'hC3);
    run_frame(1, 1, 2, 1'b0, 1'b0, tk, rd, un);
    check("post_reset_ticks", tk, 34);

    // Randomized frames against the model.
    for (int r = 0; r < 20; r++) begin
      nb = $urandom_range(4, 1);
      av = ($urandom_range(3, 0) == 0) ? $urandom_range(nb - 1, 0) : nb;
      fr_bytes.delete();
      for (int k = 0; k < nb; k++) fr_bytes.push_back(8'($urandom));
      run_frame(nb, av, $urandom_range(4, 1), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), tk, rd, un);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
